// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and UART-side byte handshakes for uart_tx_arbiter.
// The slave modport is the arbiter view; master is the system/bench view.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 3
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   tx_en;
    logic [8*N_REQ-1:0] tx_data;
    logic [N_REQ-1:0]   tx_busy;
    logic [N_REQ-1:0]   grant;
    logic [2:0]         owner_id;
    logic               timeout;
    logic               uart_tx_en;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_busy;

    modport slave (
        input  req, tx_en, tx_data, uart_tx_busy,
        output tx_busy, grant, owner_id, timeout, uart_tx_en, uart_tx_data
    );

    modport master (
        output req, tx_en, tx_data, uart_tx_busy,
        input  tx_busy, grant, owner_id, timeout, uart_tx_en, uart_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one byte-wide UART transmitter
// between N_REQ senders. Each sender sees a private en/data/busy port; a
// watchdog revokes the grant from an owner that stops sending.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned GUARD   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned IdxW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned GuardW = $clog2(GUARD + 1);
    localparam int unsigned IdleW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StOwn, StDrain} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [2:0]         owner_q, owner_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GuardW-1:0]  guard_cnt_q, guard_cnt_d;
    logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
    logic               uart_en_q, uart_en_d;
    logic [7:0]         uart_data_q, uart_data_d;
    logic               timeout_q, timeout_d;

    logic [N_REQ-1:0]   tx_busy;
    logic               fwd;
    logic               owner_req;
    logic               idle_cycle;
    logic [7:0]         owner_data;
    logic [IdxW-1:0]    sel;
    logic               sel_valid;
    logic [IdxW-1:0]    owner_idx;

    assign owner_idx = owner_q[IdxW-1:0];

    // Only the owner can ever see busy low, and only once guard and UART are both idle.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            tx_busy[i] = !(grant_q[i] && (state_q == StOwn) && (guard_cnt_q == '0) &&
                           !bus.uart_tx_busy);
        end
    end

    // Since non-owners are always busy, any accepted strobe belongs to the owner.
    assign fwd        = |(bus.tx_en & ~tx_busy);
    assign owner_req  = |(bus.req & grant_q);
    assign idle_cycle = (state_q == StOwn) && !fwd && (|(grant_q & ~tx_busy));

    // Owner byte mux driven by the one-hot grant.
    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_data = owner_data | bus.tx_data[8*i +: 8];
            end
        end
    end

    // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % N_REQ;
            if (!sel_valid && bus.req[idx]) begin
                sel_valid = 1'b1;
                sel       = idx[IdxW-1:0];
            end
        end
    end

    // Next-state logic: grant lifecycle, byte forwarding, guard and watchdog counters.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        guard_cnt_d = (guard_cnt_q == '0) ? '0 : guard_cnt_q - 1'b1;
        idle_cnt_d  = idle_cnt_q;
        uart_en_d   = 1'b0;
        uart_data_d = uart_data_q;
        timeout_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    grant_d    = N_REQ'(1) << sel;
                    owner_d    = 3'(sel);
                    idle_cnt_d = '0;
                    state_d    = StOwn;
                end
            end
            StOwn: begin
                if (fwd) begin
                    uart_en_d   = 1'b1;
                    uart_data_d = owner_data;
                    guard_cnt_d = GuardW'(GUARD);
                    idle_cnt_d  = '0;
                end else if (idle_cycle && (TIMEOUT != 0)) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                // Release wins over a coincident watchdog expiry.
                if (!owner_req) begin
                    state_d = StDrain;
                end else if ((TIMEOUT != 0) && idle_cycle &&
                             (idle_cnt_q == IdleW'(TIMEOUT - 1))) begin
                    timeout_d = 1'b1;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if ((guard_cnt_q == '0) && !bus.uart_tx_busy) begin
                    grant_d  = '0;
                    owner_d  = '0;
                    rr_ptr_d = (owner_idx == IdxW'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            guard_cnt_q <= '0;
            idle_cnt_q  <= '0;
            uart_en_q   <= 1'b0;
            uart_data_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            guard_cnt_q <= guard_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            uart_en_q   <= uart_en_d;
            uart_data_q <= uart_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.tx_busy      = tx_busy;
    assign bus.grant        = grant_q;
    assign bus.owner_id     = owner_q;
    assign bus.timeout      = timeout_q;
    assign bus.uart_tx_en   = uart_en_q;
    assign bus.uart_tx_data = uart_data_q;
endmodule
